// File: rtl/rx_stream_arbiter.sv
// rx_stream_arbiter
// Round-robin readout arbiter between NUM_CH per-channel RX sample FIFOs and
// a byte-wide valid/ready stream. The granted channel supplies up to
// BURST_LEN words per grant. Each word is serialised MSB byte first.
// Optional feature: define RX_ARB_CH_TAG_EN to emit one channel header byte
// {2'b11, 2'b00, ch[3:0]} before each burst.
module rx_stream_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int WORD_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic                     i_sys_clk,
  input  logic                     i_rst_b,
  input  logic [NUM_CH-1:0]        i_ch_enable,
  input  logic [NUM_CH-1:0]        i_fifo_empty,
  input  logic [NUM_CH*WORD_W-1:0] i_fifo_data,
  output logic [NUM_CH-1:0]        o_fifo_pull,
  output logic [7:0]               o_byte,
  output logic                     o_byte_valid,
  input  logic                     i_byte_ready,
  output logic [3:0]               o_active_ch,
  output logic                     o_busy
);

  localparam int BYTES = WORD_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WC_W  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef RX_ARB_CH_TAG_EN
    ST_HDR,
`endif
    ST_PULL,
    ST_LATCH,
    ST_SEND
  } state_t;

  state_t              state_q;
  logic [3:0]          rr_ptr_q;
  logic [3:0]          active_ch_q;
  logic [NUM_CH-1:0]   gnt_q;
  logic [NUM_CH-1:0]   pull_q;
  logic [WC_W-1:0]     word_cnt_q;
  logic [BC_W-1:0]     byte_cnt_q;
  logic [WORD_W-1:0]   shift_q;
  logic [7:0]          byte_q;
  logic                valid_q;
  logic                busy_q;

  logic [NUM_CH-1:0]   req;
  logic [NUM_CH-1:0]   req_rot;
  logic                found;
  logic [4:0]          gnt_sum;
  logic [3:0]          gnt_ch_d;
  logic [NUM_CH-1:0]   gnt_oh_d;
  logic [WORD_W-1:0]   word_sel;
  logic                ch_ready;
  logic                more_words;
  logic [3:0]          rr_ptr_d;

  // Round-robin pick: rotate the request vector so rr_ptr sits at bit 0,
  // take the first set bit and map it back to an absolute channel number.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch is inferred.
    found    = 1'b0;
    gnt_sum  = {1'b0, rr_ptr_q};
    gnt_oh_d = '0;
    req      = i_ch_enable & ~i_fifo_empty;
    req_rot  = NUM_CH'({req, req} >> rr_ptr_q);
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && req_rot[i]) begin
        found   = 1'b1;
        gnt_sum = {1'b0, rr_ptr_q} + 5'(i);
      end
    end
    gnt_ch_d = (gnt_sum >= 5'(NUM_CH)) ? 4'(gnt_sum - 5'(NUM_CH)) : gnt_sum[3:0];
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_oh_d[i] = (gnt_ch_d == 4'(i));
    end
  end

  // Granted channel's data word and its continue-the-burst condition.
  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_q[i]) word_sel = word_sel | i_fifo_data[i*WORD_W +: WORD_W];
    end
    ch_ready   = |(gnt_q & i_ch_enable & ~i_fifo_empty);
    more_words = ((int'(word_cnt_q) + 1) < BURST_LEN) && ch_ready;
    rr_ptr_d   = (active_ch_q == 4'(NUM_CH - 1)) ? 4'd0 : active_ch_q + 4'd1;
  end

  // Control FSM with all stream and FIFO outputs registered.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      // NOTE: the shift register is reset along with the control state so a
      // word caught mid-transfer can never leak out after reset.
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      active_ch_q <= '0;
      gnt_q       <= '0;
      pull_q      <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state_q)
        ST_IDLE: begin
          if (|req) begin
            gnt_q       <= gnt_oh_d;
            active_ch_q <= gnt_ch_d;
            word_cnt_q  <= '0;
            busy_q      <= 1'b1;
`ifdef RX_ARB_CH_TAG_EN
            byte_q      <= {2'b11, 2'b00, gnt_ch_d};
            valid_q     <= 1'b1;
            state_q     <= ST_HDR;
`else
            pull_q      <= gnt_oh_d;
            state_q     <= ST_PULL;
`endif
          end
        end
`ifdef RX_ARB_CH_TAG_EN
        ST_HDR: begin
          // Header is held until accepted; only then is the FIFO touched.
          if (i_byte_ready) begin
            valid_q <= 1'b0;
            pull_q  <= gnt_q;
            state_q <= ST_PULL;
          end
        end
`endif
        ST_PULL: begin
          pull_q  <= '0;
          state_q <= ST_LATCH;
        end
        ST_LATCH: begin
          byte_q     <= word_sel[WORD_W-1 -: 8];
          shift_q    <= word_sel << 8;
          byte_cnt_q <= BC_W'(BYTES - 1);
          valid_q    <= 1'b1;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          if (i_byte_ready) begin
            if (byte_cnt_q == '0) begin
              word_cnt_q <= word_cnt_q + WC_W'(1);
              valid_q    <= 1'b0;
              if (more_words) begin
                pull_q  <= gnt_q;
                state_q <= ST_PULL;
              end else begin
                rr_ptr_q    <= rr_ptr_d;
                active_ch_q <= '0;
                gnt_q       <= '0;
                busy_q      <= 1'b0;
                state_q     <= ST_IDLE;
              end
            end else begin
              byte_q     <= shift_q[WORD_W-1 -: 8];
              shift_q    <= shift_q << 8;
              byte_cnt_q <= byte_cnt_q - BC_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_fifo_pull  = pull_q;
  assign o_byte       = byte_q;
  assign o_byte_valid = valid_q;
  assign o_active_ch  = active_ch_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_rx_stream_arbiter.sv
// Self-checking bench for rx_stream_arbiter (NUM_CH=2, WORD_W=32, BURST_LEN=4).
// Cycle-exact vector table for the single-word and backpressure cases, plus
// hand-written sequences for round-robin, empty/disable, reset and header.
module tb_rx_stream_arbiter;

`ifdef RX_ARB_CH_TAG_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_b;
  logic [1:0]  ch_enable;
  logic [1:0]  fifo_empty;
  logic [63:0] fifo_data;
  logic [1:0]  fifo_pull;
  logic [7:0]  byte_o;
  logic        byte_valid;
  logic        byte_ready;
  logic [3:0]  active_ch;
  logic        busy;

  always #5 clk = ~clk;

  rx_stream_arbiter #(.NUM_CH(2), .WORD_W(32), .BURST_LEN(4)) dut (
    .i_sys_clk    (clk),
    .i_rst_b      (rst_b),
    .i_ch_enable  (ch_enable),
    .i_fifo_empty (fifo_empty),
    .i_fifo_data  (fifo_data),
    .o_fifo_pull  (fifo_pull),
    .o_byte       (byte_o),
    .o_byte_valid (byte_valid),
    .i_byte_ready (byte_ready),
    .o_active_ch  (active_ch),
    .o_busy       (busy)
  );

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [7:0]  cap[$];
  logic [7:0]  exp_q[$];
  int          pull_cnt0, pull_cnt1, pull_empty_err;
  int          errors = 0;
  int          checks = 0;

  typedef struct packed {
    logic       rdy;
    logic [1:0] pull;
    logic       v;
    logic [7:0] b;
    logic       busy;
    logic [3:0] act;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic update_empty();
    fifo_empty = {q1.size() == 0, q0.size() == 0};
  endtask

  // Called at a negedge with inputs already driven: records what the
  // upcoming posedge will act on, advances one cycle, models the FIFOs.
  task automatic tick();
    logic [1:0] pulls;
    pulls = fifo_pull;
    if (byte_valid && byte_ready) cap.push_back(byte_o);
    @(posedge clk);
    #1;
    if (pulls[0]) begin
      pull_cnt0++;
      if (q0.size() == 0) pull_empty_err++;
      else fifo_data[31:0] = q0.pop_front();
    end
    if (pulls[1]) begin
      pull_cnt1++;
      if (q1.size() == 0) pull_empty_err++;
      else fifo_data[63:32] = q1.pop_front();
    end
    update_empty();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_b      = 1'b0;
    byte_ready = 1'b0;
    fifo_data  = '0;
    update_empty();
    repeat (2) @(negedge clk);
    cap.delete();
    exp_q.delete();
    pull_cnt0 = 0;
    pull_cnt1 = 0;
    rst_b = 1'b1;
  endtask

  task automatic run_to_idle(input string name, input int budget);
    int  n = 0;
    bit  seen = 1'b0;
    while (n < budget && !(seen && !busy)) begin
      if (busy) seen = 1'b1;
      tick();
      n++;
    end
    check({name, "_timeout"}, 64'(n < budget), 64'd1);
  endtask

  task automatic add_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic add_hdr(input logic [3:0] ch);
    if (HDR != 0) exp_q.push_back({4'b1100, ch});
  endtask

  task automatic compare_stream(input string name);
    check({name, "_len"}, 64'(cap.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap.size()) check($sformatf("%s[%0d]", name, i), 64'(cap[i]), 64'(exp_q[i]));
    end
  endtask

  initial begin
    vec_t tbl[17];
    int   n;
    rst_b      = 1'b0;
    ch_enable  = 2'b11;
    byte_ready = 1'b0;
    fifo_data  = '0;
    pull_empty_err = 0;
    update_empty();

`ifndef RX_ARB_CH_TAG_EN
    // ---- single word on ch0, then backpressured word on ch1 ----
    //          rdy   pull   v     byte   busy  act
    tbl[0]  = '{1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 2'b01, 1'b0, 8'h00, 1'b1, 4'd0};
    tbl[2]  = '{1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 4'd0};
    tbl[3]  = '{1'b1, 2'b00, 1'b1, 8'h5A, 1'b1, 4'd0};
    tbl[4]  = '{1'b1, 2'b00, 1'b1, 8'hC3, 1'b1, 4'd0};
    tbl[5]  = '{1'b1, 2'b00, 1'b1, 8'hE7, 1'b1, 4'd0};
    tbl[6]  = '{1'b1, 2'b00, 1'b1, 8'hF1, 1'b1, 4'd0};
    tbl[7]  = '{1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 4'd0};
    tbl[8]  = '{1'b1, 2'b10, 1'b0, 8'h00, 1'b1, 4'd1};
    tbl[9]  = '{1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 4'd1};
    tbl[10] = '{1'b1, 2'b00, 1'b1, 8'h12, 1'b1, 4'd1};
    tbl[11] = '{1'b0, 2'b00, 1'b1, 8'h34, 1'b1, 4'd1};
    tbl[12] = '{1'b0, 2'b00, 1'b1, 8'h34, 1'b1, 4'd1};
    tbl[13] = '{1'b1, 2'b00, 1'b1, 8'h34, 1'b1, 4'd1};
    tbl[14] = '{1'b1, 2'b00, 1'b1, 8'h56, 1'b1, 4'd1};
    tbl[15] = '{1'b1, 2'b00, 1'b1, 8'h78, 1'b1, 4'd1};
    tbl[16] = '{1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 4'd0};
    q0.push_back(32'h5AC3E7F1);
    q1.push_back(32'h12345678);
    do_reset();
    for (int i = 0; i < 17; i++) begin
      check($sformatf("vec[%0d]", i),
            64'({fifo_pull, byte_valid, (tbl[i].v ? byte_o : 8'h00), busy, active_ch}),
            64'({tbl[i].pull, tbl[i].v, tbl[i].b, tbl[i].busy, tbl[i].act}));
      byte_ready = tbl[i].rdy;
      tick();
    end
    add_word(32'h5AC3E7F1);
    add_word(32'h12345678);
    compare_stream("vec_stream");
    check("vec_pulls", 64'({pull_cnt1, pull_cnt0}), {32'd1, 32'd1});
`else
    // ---- header: held while not ready, pull only after acceptance ----
    q1.push_back(32'hA5A5A500);
    do_reset();
    check("hdr_reset", 64'({fifo_pull, byte_valid, byte_o, busy, active_ch}), 64'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hdr_hold[%0d]", i),
            64'({fifo_pull, byte_valid, byte_o, active_ch}), 64'({2'b00, 1'b1, 8'hC1, 4'd1}));
      check($sformatf("hdr_nopull[%0d]", i), 64'(pull_cnt1), 64'd0);
      tick();
    end
    byte_ready = 1'b1;
    run_to_idle("hdr", 40);
    add_hdr(4'd1);
    add_word(32'hA5A5A500);
    compare_stream("hdr_stream");
    check("hdr_pulls", 64'(pull_cnt1), 64'd1);
`endif

    // ---- round-robin: 6 words per channel, bursts of 4 ----
    ch_enable = 2'b11;
    for (int i = 0; i < 6; i++) begin
      q0.push_back(32'h00000000 + 32'(i));
      q1.push_back(32'h11111110 + 32'(i));
    end
    do_reset();
    byte_ready = 1'b1;
    n = 0;
    while (n < 400 && (q0.size() != 0 || q1.size() != 0 || busy || cap.size() < 48 + 4*HDR)) begin
      tick();
      n++;
    end
    check("rr_timeout", 64'(n < 400), 64'd1);
    add_hdr(4'd0);
    for (int i = 0; i < 4; i++) add_word(32'h00000000 + 32'(i));
    add_hdr(4'd1);
    for (int i = 0; i < 4; i++) add_word(32'h11111110 + 32'(i));
    add_hdr(4'd0);
    for (int i = 4; i < 6; i++) add_word(32'h00000000 + 32'(i));
    add_hdr(4'd1);
    for (int i = 4; i < 6; i++) add_word(32'h11111110 + 32'(i));
    compare_stream("rr");
    check("rr_pulls", 64'({pull_cnt1, pull_cnt0}), {32'd6, 32'd6});

    // ---- ch0 empties after 2 words, ch1 disabled ----
    q0.push_back(32'hAAAA0001);
    q0.push_back(32'hAAAA0002);
    q1.push_back(32'hBBBB0001);
    q1.push_back(32'hBBBB0002);
    ch_enable = 2'b01;
    do_reset();
    byte_ready = 1'b1;
    run_to_idle("empty", 60);
    add_hdr(4'd0);
    add_word(32'hAAAA0001);
    add_word(32'hAAAA0002);
    compare_stream("empty");
    check("empty_ch1_pulls", 64'(pull_cnt1), 64'd0);
    check("empty_ch1_left", 64'(q1.size()), 64'd2);
    repeat (5) tick();
    check("empty_stays_idle", 64'({busy, byte_valid, fifo_pull}), 64'd0);

    // ---- reset in the middle of SEND ----
    q1.delete();
    q0.push_back(32'hDEADBEEF);
    q0.push_back(32'h01020304);
    ch_enable = 2'b11;
    do_reset();
    byte_ready = 1'b1;
    n = 0;
    while (n < 60 && cap.size() < 2 + HDR) begin
      tick();
      n++;
    end
    check("rst_reach_timeout", 64'(n < 60), 64'd1);
    rst_b = 1'b0;
    #1;
    check("rst_outputs", 64'({fifo_pull, byte_valid, byte_o, busy, active_ch}), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    cap.delete();
    exp_q.delete();
    run_to_idle("rst", 60);
    add_hdr(4'd0);
    add_word(32'h01020304);
    compare_stream("rst");

    check("pull_while_empty", 64'(pull_empty_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
